// File: rtl/multi_port_bram_memory_subsystem.sv
// Shared word memory: a dedicated fetch read port plus NUM_D_PORTS data requesters
// multiplexed onto the second port by a round-robin arbiter, with 1- or 2-cycle read latency.
module multi_port_bram_memory_subsystem #(
   parameter int DATA_WIDTH       = 32,
   parameter int ADDRESS_BITS     = 32,
   parameter int MEM_ADDRESS_BITS = 12,
   parameter int NUM_D_PORTS      = 2,
   parameter int READ_LATENCY     = 1
)(
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  i_mem_read,
   input  logic [ADDRESS_BITS-1:0]               i_mem_address_in,
   output logic [DATA_WIDTH-1:0]                 i_mem_data_out,
   output logic [ADDRESS_BITS-1:0]               i_mem_address_out,
   output logic                                  i_mem_valid,
   output logic                                  i_mem_ready,
   input  logic [NUM_D_PORTS-1:0]                d_mem_read,
   input  logic [NUM_D_PORTS-1:0]                d_mem_write,
   input  logic [NUM_D_PORTS*DATA_WIDTH/8-1:0]   d_mem_byte_en,
   input  logic [NUM_D_PORTS*ADDRESS_BITS-1:0]   d_mem_address_in,
   input  logic [NUM_D_PORTS*DATA_WIDTH-1:0]     d_mem_data_in,
   output logic [NUM_D_PORTS*DATA_WIDTH-1:0]     d_mem_data_out,
   output logic [NUM_D_PORTS*ADDRESS_BITS-1:0]   d_mem_address_out,
   output logic [NUM_D_PORTS-1:0]                d_mem_valid,
   output logic [NUM_D_PORTS-1:0]                d_mem_ready
);
   localparam int BYTES    = DATA_WIDTH / 8;
   localparam int WORD_LSB = (BYTES > 1) ? $clog2(BYTES) : 0;
   localparam int DEPTH    = 2 ** MEM_ADDRESS_BITS;
   localparam int RR_BITS  = (NUM_D_PORTS > 1) ? $clog2(NUM_D_PORTS) : 1;
   localparam int LAST     = READ_LATENCY - 1;

   logic [DATA_WIDTH-1:0]       mem [0:DEPTH-1];

   logic [RR_BITS-1:0]          rr_reg;
   logic [NUM_D_PORTS-1:0]      req;
   logic [NUM_D_PORTS-1:0]      grant_onehot;
   logic [RR_BITS-1:0]          grant_idx;
   logic                        grant_found;

   logic [ADDRESS_BITS-1:0]     sel_addr;
   logic [DATA_WIDTH-1:0]       sel_wdata;
   logic [BYTES-1:0]            sel_be;
   logic [MEM_ADDRESS_BITS-1:0] d_word;
   logic [MEM_ADDRESS_BITS-1:0] i_word;
   logic                        d_write_en;
   logic                        d_read_en;

   // Read pipeline; data stages carry no reset so they map onto the RAM output registers.
   logic [DATA_WIDTH-1:0]       d_pipe_data  [READ_LATENCY];
   logic                        d_pipe_valid [READ_LATENCY];
   logic [RR_BITS-1:0]          d_pipe_port  [READ_LATENCY];
   logic [ADDRESS_BITS-1:0]     d_pipe_addr  [READ_LATENCY];
   logic [DATA_WIDTH-1:0]       i_pipe_data  [READ_LATENCY];
   logic                        i_pipe_valid [READ_LATENCY];
   logic [ADDRESS_BITS-1:0]     i_pipe_addr  [READ_LATENCY];

   logic [DATA_WIDTH-1:0]       i_hold_data_reg;
   logic [ADDRESS_BITS-1:0]     i_hold_addr_reg;

   assign req = d_mem_read | d_mem_write;

   // Descending scan so the closest requester at or above rr wins the last assignment.
   always_comb begin
      int cand;
      grant_found  = 1'b0;
      grant_idx    = '0;
      grant_onehot = '0;
      for (int i = NUM_D_PORTS - 1; i >= 0; i--) begin
         cand = int'(rr_reg) + i;
         if (cand >= NUM_D_PORTS) cand = cand - NUM_D_PORTS;
         if (req[RR_BITS'(cand)]) begin
            grant_found = 1'b1;
            grant_idx   = RR_BITS'(cand);
         end
      end
      grant_onehot[grant_idx] = grant_found;
   end

   assign d_mem_ready = reset ? '0 : grant_onehot;
   assign i_mem_ready = ~reset;

   assign sel_addr   = d_mem_address_in[int'(grant_idx)*ADDRESS_BITS +: ADDRESS_BITS];
   assign sel_wdata  = d_mem_data_in[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
   assign sel_be     = d_mem_byte_en[int'(grant_idx)*BYTES +: BYTES];
   assign d_word     = sel_addr[WORD_LSB +: MEM_ADDRESS_BITS];
   assign i_word     = i_mem_address_in[WORD_LSB +: MEM_ADDRESS_BITS];
   assign d_write_en = ~reset & grant_found & d_mem_write[grant_idx];
   assign d_read_en  = grant_found & d_mem_read[grant_idx];

   // Nonblocking read of the old word alongside the write gives read-first behaviour on both ports.
   always_ff @(posedge clock) begin
      if (d_write_en) begin
         for (int b = 0; b < BYTES; b++) begin
            if (sel_be[b]) mem[d_word][b*8 +: 8] <= sel_wdata[b*8 +: 8];
         end
      end
      d_pipe_data[0] <= mem[d_word];
      i_pipe_data[0] <= mem[i_word];
      for (int s = 1; s < READ_LATENCY; s++) begin
         d_pipe_data[s] <= d_pipe_data[s-1];
         i_pipe_data[s] <= i_pipe_data[s-1];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rr_reg <= '0;
         for (int s = 0; s < READ_LATENCY; s++) begin
            d_pipe_valid[s] <= 1'b0;
            d_pipe_port[s]  <= '0;
            d_pipe_addr[s]  <= '0;
            i_pipe_valid[s] <= 1'b0;
            i_pipe_addr[s]  <= '0;
         end
      end else begin
         if (grant_found) begin
            rr_reg <= (grant_idx == RR_BITS'(NUM_D_PORTS - 1)) ? '0 : grant_idx + 1'b1;
         end
         d_pipe_valid[0] <= d_read_en;
         d_pipe_port[0]  <= grant_idx;
         d_pipe_addr[0]  <= sel_addr;
         i_pipe_valid[0] <= i_mem_read;
         i_pipe_addr[0]  <= i_mem_address_in;
         for (int s = 1; s < READ_LATENCY; s++) begin
            d_pipe_valid[s] <= d_pipe_valid[s-1];
            d_pipe_port[s]  <= d_pipe_port[s-1];
            d_pipe_addr[s]  <= d_pipe_addr[s-1];
            i_pipe_valid[s] <= i_pipe_valid[s-1];
            i_pipe_addr[s]  <= i_pipe_addr[s-1];
         end
      end
   end

   assign i_mem_valid       = i_pipe_valid[LAST];
   assign i_mem_data_out    = i_pipe_valid[LAST] ? i_pipe_data[LAST] : i_hold_data_reg;
   assign i_mem_address_out = i_pipe_valid[LAST] ? i_pipe_addr[LAST] : i_hold_addr_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         i_hold_data_reg <= '0;
         i_hold_addr_reg <= '0;
      end else if (i_pipe_valid[LAST]) begin
         i_hold_data_reg <= i_pipe_data[LAST];
         i_hold_addr_reg <= i_pipe_addr[LAST];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_D_PORTS; gi++) begin : g_port
         logic                    hit;
         logic [DATA_WIDTH-1:0]   data_hold_reg;
         logic [ADDRESS_BITS-1:0] addr_hold_reg;

         assign hit = d_pipe_valid[LAST] && (d_pipe_port[LAST] == RR_BITS'(gi));
         assign d_mem_valid[gi] = hit;
         assign d_mem_data_out[gi*DATA_WIDTH +: DATA_WIDTH] =
            hit ? d_pipe_data[LAST] : data_hold_reg;
         assign d_mem_address_out[gi*ADDRESS_BITS +: ADDRESS_BITS] =
            hit ? d_pipe_addr[LAST] : addr_hold_reg;

         always_ff @(posedge clock) begin
            if (reset) begin
               data_hold_reg <= '0;
               addr_hold_reg <= '0;
            end else if (hit) begin
               data_hold_reg <= d_pipe_data[LAST];
               addr_hold_reg <= d_pipe_addr[LAST];
            end
         end
      end
   endgenerate
endmodule

// File: tb/tb_multi_port_bram_memory_subsystem.sv
// Drives a 1-cycle and a 2-cycle latency instance with identical stimulus and checks both
// against a reference memory model and a due-cycle scoreboard.
module tb_multi_port_bram_memory_subsystem;
   logic        clock = 1'b0;
   logic        reset;
   logic        i_mem_read;
   logic [31:0] i_mem_address_in;
   logic [1:0]  d_mem_read, d_mem_write;
   logic [7:0]  d_mem_byte_en;
   logic [63:0] d_mem_address_in, d_mem_data_in;

   logic [31:0] i_data1, i_addr1, i_data2, i_addr2;
   logic        i_valid1, i_ready1, i_valid2, i_ready2;
   logic [63:0] d_data1, d_addr1, d_data2, d_addr2;
   logic [1:0]  d_valid1, d_ready1, d_valid2, d_ready2;

   always #5 clock = ~clock;

   multi_port_bram_memory_subsystem #(.READ_LATENCY(1)) dut1 (
      .clock(clock), .reset(reset),
      .i_mem_read(i_mem_read), .i_mem_address_in(i_mem_address_in),
      .i_mem_data_out(i_data1), .i_mem_address_out(i_addr1),
      .i_mem_valid(i_valid1), .i_mem_ready(i_ready1),
      .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_byte_en(d_mem_byte_en),
      .d_mem_address_in(d_mem_address_in), .d_mem_data_in(d_mem_data_in),
      .d_mem_data_out(d_data1), .d_mem_address_out(d_addr1),
      .d_mem_valid(d_valid1), .d_mem_ready(d_ready1));

   multi_port_bram_memory_subsystem #(.READ_LATENCY(2)) dut2 (
      .clock(clock), .reset(reset),
      .i_mem_read(i_mem_read), .i_mem_address_in(i_mem_address_in),
      .i_mem_data_out(i_data2), .i_mem_address_out(i_addr2),
      .i_mem_valid(i_valid2), .i_mem_ready(i_ready2),
      .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_byte_en(d_mem_byte_en),
      .d_mem_address_in(d_mem_address_in), .d_mem_data_in(d_mem_data_in),
      .d_mem_data_out(d_data2), .d_mem_address_out(d_addr2),
      .d_mem_valid(d_valid2), .d_mem_ready(d_ready2));

   typedef struct {
      logic        rst;
      logic        ird;
      logic [31:0] iaddr;
      logic [1:0]  rd, wr;
      logic [3:0]  be0, be1;
      logic [31:0] a0, w0, a1, w1;
      logic [1:0]  rdy;
   } vec_t;

   typedef struct {
      int          due;
      int          lat;
      int          port;
      logic [31:0] data;
      logic [31:0] addr;
   } exp_t;

   vec_t        tbl[$];
   exp_t        sb_q[$];
   logic [31:0] model_mem [int];
   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;

   function automatic vec_t mk(logic rst, logic ird, logic [31:0] iaddr, logic [1:0] rd,
                               logic [1:0] wr, logic [3:0] be0, logic [31:0] a0, logic [31:0] w0,
                               logic [3:0] be1, logic [31:0] a1, logic [31:0] w1, logic [1:0] rdy);
      vec_t v;
      v.rst = rst; v.ird = ird; v.iaddr = iaddr; v.rd = rd; v.wr = wr;
      v.be0 = be0; v.a0 = a0; v.w0 = w0; v.be1 = be1; v.a1 = a1; v.w1 = w1; v.rdy = rdy;
      return v;
   endfunction

   function automatic int widx(logic [31:0] a);
      return int'((a >> 2) & 32'hFFF);
   endfunction

   function automatic logic [31:0] model_rd(logic [31:0] a);
      return model_mem.exists(widx(a)) ? model_mem[widx(a)] : 32'h0;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic void get_out(input int lat, input int p, output logic v,
                                   output logic [31:0] d, output logic [31:0] a);
      if (lat == 1) begin
         if (p == 2) begin v = i_valid1; d = i_data1; a = i_addr1; end
         else begin v = d_valid1[p]; d = d_data1[p*32 +: 32]; a = d_addr1[p*32 +: 32]; end
      end else begin
         if (p == 2) begin v = i_valid2; d = i_data2; a = i_addr2; end
         else begin v = d_valid2[p]; d = d_data2[p*32 +: 32]; a = d_addr2[p*32 +: 32]; end
      end
   endfunction

   task automatic check_outputs();
      logic        v;
      logic [31:0] d, a;
      int          found;
      string       name;
      for (int lat = 1; lat <= 2; lat++) begin
         for (int p = 0; p < 3; p++) begin
            get_out(lat, p, v, d, a);
            found = -1;
            foreach (sb_q[i]) begin
               if (found < 0 && sb_q[i].due == cyc && sb_q[i].lat == lat && sb_q[i].port == p)
                  found = i;
            end
            name = $sformatf("c%0d L%0d %s", cyc, lat, (p == 2) ? "fetch" : $sformatf("port%0d", p));
            if (found >= 0) begin
               $display("[TB] %s read addr=%h data=%h", name, a, d);
               chk({name, " valid"}, {63'b0, v}, 64'd1);
               chk({name, " data"}, {32'b0, d}, {32'b0, sb_q[found].data});
               chk({name, " addr"}, {32'b0, a}, {32'b0, sb_q[found].addr});
               sb_q.delete(found);
            end else begin
               chk({name, " valid"}, {63'b0, v}, 64'd0);
            end
         end
      end
   endtask

   task automatic push_read(int port, logic [31:0] addr);
      exp_t e;
      e.port = port; e.addr = addr; e.data = model_rd(addr);
      e.lat = 1; e.due = cyc + 1; sb_q.push_back(e);
      e.lat = 2; e.due = cyc + 2; sb_q.push_back(e);
   endtask

   task automatic model_wr(logic [31:0] a, logic [31:0] w, logic [3:0] be);
      logic [31:0] t;
      t = model_rd(a);
      for (int b = 0; b < 4; b++) if (be[b]) t[b*8 +: 8] = w[b*8 +: 8];
      model_mem[widx(a)] = t;
   endtask

   // Called at a falling edge: checks what the previous rising edge produced, then drives one cycle.
   task automatic run_vec(vec_t v);
      check_outputs();
      reset            = v.rst;
      i_mem_read       = v.ird;
      i_mem_address_in = v.iaddr;
      d_mem_read       = v.rd;
      d_mem_write      = v.wr;
      d_mem_byte_en    = {v.be1, v.be0};
      d_mem_address_in = {v.a1, v.a0};
      d_mem_data_in    = {v.w1, v.w0};
      #1;
      chk($sformatf("c%0d L1 d_ready", cyc), {62'b0, d_ready1}, {62'b0, v.rdy});
      chk($sformatf("c%0d L2 d_ready", cyc), {62'b0, d_ready2}, {62'b0, v.rdy});
      chk($sformatf("c%0d L1 i_ready", cyc), {63'b0, i_ready1}, {63'b0, ~v.rst});
      chk($sformatf("c%0d L2 i_ready", cyc), {63'b0, i_ready2}, {63'b0, ~v.rst});
      if (!v.rst) begin
         if (v.ird) push_read(2, v.iaddr);
         if (v.rdy[0] && v.rd[0]) push_read(0, v.a0);
         if (v.rdy[1] && v.rd[1]) push_read(1, v.a1);
         if (v.rdy[0] && v.wr[0]) model_wr(v.a0, v.w0, v.be0);
         if (v.rdy[1] && v.wr[1]) model_wr(v.a1, v.w1, v.be1);
      end else begin
         for (int i = sb_q.size() - 1; i >= 0; i--) if (sb_q[i].due > cyc) sb_q.delete(i);
      end
      @(negedge clock);
      cyc++;
   endtask

   task automatic check_idle_reset_values(string tag);
      chk({tag, " L1 d_valid"}, {62'b0, d_valid1}, 64'd0);
      chk({tag, " L2 d_valid"}, {62'b0, d_valid2}, 64'd0);
      chk({tag, " L1 i_valid"}, {63'b0, i_valid1}, 64'd0);
      chk({tag, " L2 i_valid"}, {63'b0, i_valid2}, 64'd0);
      chk({tag, " L1 d_data"}, d_data1, 64'd0);
      chk({tag, " L2 d_data"}, d_data2, 64'd0);
      chk({tag, " L1 d_addr"}, d_addr1, 64'd0);
      chk({tag, " L2 d_addr"}, d_addr2, 64'd0);
      chk({tag, " L1 i_data"}, {32'b0, i_data1}, 64'd0);
      chk({tag, " L2 i_addr"}, {32'b0, i_addr2}, 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; i_mem_read = 1'b0; i_mem_address_in = '0;
      d_mem_read = '0; d_mem_write = '0; d_mem_byte_en = '0;
      d_mem_address_in = '0; d_mem_data_in = '0;

      // rr starts at 0; each row's ready value follows the round-robin rule by hand.
      tbl.push_back(mk(1, 0, 0,     2'b00, 2'b01, 4'hF, 32'h10, 32'hDEADBEEF, 0, 0, 0, 2'b00));
      tbl.push_back(mk(0, 0, 0,     2'b00, 2'b01, 4'hF, 32'h10, 32'hDEADBEEF, 0, 0, 0, 2'b01));
      tbl.push_back(mk(0, 0, 0,     2'b01, 2'b00, 4'h0, 32'h10, 0,            0, 0, 0, 2'b01));
      tbl.push_back(mk(0, 0, 0,     2'b00, 2'b01, 4'h5, 32'h10, 32'h11223344, 0, 0, 0, 2'b01));
      tbl.push_back(mk(0, 0, 0,     2'b01, 2'b00, 4'h0, 32'h10, 0,            0, 0, 0, 2'b01));
      tbl.push_back(mk(0, 0, 0,     2'b00, 2'b10, 4'h0, 0, 0, 4'hF, 32'h20, 32'h0, 2'b10));
      tbl.push_back(mk(0, 1, 32'h20, 2'b00, 2'b01, 4'hF, 32'h20, 32'h5,      0, 0, 0, 2'b01));
      tbl.push_back(mk(0, 1, 32'h20, 2'b00, 2'b00, 4'h0, 0, 0,               0, 0, 0, 2'b00));
      tbl.push_back(mk(0, 0, 0,     2'b00, 2'b10, 4'h0, 0, 0, 4'hF, 32'h4004, 32'hCAFEF00D, 2'b10));
      tbl.push_back(mk(0, 0, 0,     2'b11, 2'b00, 4'h0, 32'h4, 0, 0, 32'h4004, 0, 2'b01));
      tbl.push_back(mk(0, 0, 0,     2'b11, 2'b00, 4'h0, 32'h4, 0, 0, 32'h4004, 0, 2'b10));
      tbl.push_back(mk(0, 0, 0,     2'b11, 2'b00, 4'h0, 32'h4, 0, 0, 32'h4004, 0, 2'b01));
      tbl.push_back(mk(0, 0, 0,     2'b11, 2'b00, 4'h0, 32'h4, 0, 0, 32'h4004, 0, 2'b10));
      tbl.push_back(mk(0, 0, 0,     2'b10, 2'b00, 4'h0, 0, 0, 0, 32'h4004, 0, 2'b10));
      tbl.push_back(mk(0, 0, 0,     2'b10, 2'b00, 4'h0, 0, 0, 0, 32'h4004, 0, 2'b10));
      tbl.push_back(mk(0, 0, 0,     2'b01, 2'b01, 4'h8, 32'h10, 32'hFFFFFFFF, 0, 0, 0, 2'b01));
      tbl.push_back(mk(0, 0, 0,     2'b11, 2'b00, 4'h0, 32'h10, 0, 0, 32'h20, 0, 2'b10));
      tbl.push_back(mk(0, 1, 32'h4004, 2'b01, 2'b00, 4'h0, 32'h10, 0,        0, 0, 0, 2'b01));
      tbl.push_back(mk(0, 0, 0,     2'b00, 2'b00, 4'h0, 0, 0, 0, 0, 0, 2'b00));
      tbl.push_back(mk(0, 0, 0,     2'b00, 2'b00, 4'h0, 0, 0, 0, 0, 0, 2'b00));

      repeat (3) @(negedge clock);
      check_idle_reset_values("reset");
      chk("reset L1 ready", {61'b0, i_ready1, d_ready1}, 64'd0);
      chk("reset L2 ready", {61'b0, i_ready2, d_ready2}, 64'd0);

      foreach (tbl[i]) run_vec(tbl[i]);

      // Idle ports keep their last returned word and address.
      chk("hold L1 port0 data", {32'b0, d_data1[31:0]},  64'hFF22BE44);
      chk("hold L2 port1 data", {32'b0, d_data2[63:32]}, 64'h5);
      chk("hold L1 port1 addr", {32'b0, d_addr1[63:32]}, 64'h20);

      // Reset lands one cycle after a read is accepted: the 2-cycle pipe must drop it,
      // the write offered during reset must be ignored, and rr must restart at 0.
      run_vec(mk(0, 1, 32'h10, 2'b01, 2'b00, 4'h0, 32'h10, 0, 0, 0, 0, 2'b01));
      run_vec(mk(1, 0, 0,      2'b00, 2'b01, 4'hF, 32'h10, 32'h0, 0, 0, 0, 2'b00));
      check_idle_reset_values("post-reset");
      run_vec(mk(0, 0, 0, 2'b11, 2'b00, 4'h0, 32'h10, 0, 0, 32'h20, 0, 2'b01));
      run_vec(mk(0, 0, 0, 2'b11, 2'b00, 4'h0, 32'h10, 0, 0, 32'h20, 0, 2'b10));
      run_vec(mk(0, 0, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0, 0, 2'b00));
      run_vec(mk(0, 0, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0, 0, 2'b00));
      chk("scoreboard drained", 64'(sb_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
